// File: rtl/irq_ctrl_if.sv
// Register-window bus between the system bridge and the interrupt controller.
// The bridge drives address, strobe and write data; the controller returns read data.
interface irq_ctrl_if;
   logic [3:2]  ADD_I;
   logic        WE_I;
   logic [31:0] DAT_I;
   logic [31:0] DAT_O;

   modport master (output ADD_I, WE_I, DAT_I, input DAT_O);
   modport slave  (input ADD_I, WE_I, DAT_I, output DAT_O);
endinterface

// File: rtl/irq_ctrl.sv
// Interrupt controller: latches device IRQs into PENDING, masks and prioritises them,
// and walks the winner through request, acknowledge and end-of-interrupt.
module irq_ctrl #(
   parameter int N_SRC = 6
) (
   input  logic             CLK_I,
   input  logic             RST_I,
   irq_ctrl_if.slave        bus,
   input  logic [N_SRC-1:0] IRQ_SRC_I,
   input  logic             ACK_I,
   output logic             IRQ_O,
   output logic [4:0]       ISR_IDX_O
);

   typedef enum logic [1:0] {
      IDLE    = 2'b00,
      REQ     = 2'b01,
      SERVICE = 2'b10
   } state_t;

   localparam logic [1:0] A_MASK  = 2'd0;
   localparam logic [1:0] A_PEND  = 2'd1;
   localparam logic [1:0] A_CAUSE = 2'd2;
   localparam logic [1:0] A_EDGE  = 2'd3;

   state_t           state;
   state_t           state_nxt;
   logic [N_SRC-1:0] mask;
   logic [N_SRC-1:0] pending;
   logic [N_SRC-1:0] edge_mode;
   logic [N_SRC-1:0] prev;
   logic [N_SRC-1:0] sel;
   logic [N_SRC-1:0] win_oh;
   logic [N_SRC-1:0] set_vec;
   logic [N_SRC-1:0] w1c_vec;
   logic [N_SRC-1:0] ack_clr;
   logic [4:0]       isr_idx;
   logic [4:0]       win_idx;
   logic             irq_q;
   logic             wr_mask;
   logic             wr_pend;
   logic             wr_eoi;
   logic             wr_edge;
   logic             take;
   logic             in_service;
   logic             unused_dat;

   function automatic logic [31:0] zext(input logic [N_SRC-1:0] v);
      logic [31:0] r;
      r = '0;
      r[N_SRC-1:0] = v;
      return r;
   endfunction

   assign wr_mask = bus.WE_I && (bus.ADD_I == A_MASK);
   assign wr_pend = bus.WE_I && (bus.ADD_I == A_PEND);
   assign wr_eoi  = bus.WE_I && (bus.ADD_I == A_CAUSE);
   assign wr_edge = bus.WE_I && (bus.ADD_I == A_EDGE);

   // Write data above N_SRC has no storage; the reduction keeps every bit referenced.
   assign unused_dat = ^bus.DAT_I;

   assign sel    = pending & mask;
   assign win_oh = sel & (~sel + N_SRC'(1));

   always_comb begin
      win_idx = '0;
      for (int i = N_SRC - 1; i >= 0; i--) begin
         if (sel[i]) win_idx = 5'(i);
      end
   end

   // Level sources re-set every cycle they are high; edge sources only on a 0->1 step.
   assign set_vec = IRQ_SRC_I & (~edge_mode | ~prev);
   assign w1c_vec = wr_pend ? bus.DAT_I[N_SRC-1:0] : '0;
   assign ack_clr = take ? (win_oh & edge_mode) : '0;

   always_comb begin
      state_nxt = state;
      take      = 1'b0;
      case (state)
         IDLE: begin
            if (|sel) state_nxt = REQ;
         end
         REQ: begin
            if (!(|sel)) begin
               state_nxt = IDLE;
            end else if (ACK_I) begin
               state_nxt = SERVICE;
               take      = 1'b1;
            end
         end
         SERVICE: begin
            if (wr_eoi) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge CLK_I or posedge RST_I) begin
      if (RST_I) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_ff @(posedge CLK_I or posedge RST_I) begin
      if (RST_I) begin
         mask      <= '0;
         pending   <= '0;
         edge_mode <= '0;
         prev      <= '0;
         isr_idx   <= '0;
         irq_q     <= 1'b0;
      end else begin
         if (wr_mask) mask <= bus.DAT_I[N_SRC-1:0];
         if (wr_edge) edge_mode <= bus.DAT_I[N_SRC-1:0];
         // A new set beats a same-cycle clear so no event is lost.
         pending <= (pending & ~(w1c_vec | ack_clr)) | set_vec;
         prev    <= IRQ_SRC_I;
         if (take) isr_idx <= win_idx;
         irq_q   <= (state_nxt == REQ);
      end
   end

   assign in_service = (state == SERVICE);

   always_comb begin
      bus.DAT_O = '0;
      case (bus.ADD_I)
         A_MASK:  bus.DAT_O = zext(mask);
         A_PEND:  bus.DAT_O = zext(pending);
         A_CAUSE: bus.DAT_O = {22'b0, state, in_service, 2'b0, isr_idx};
         A_EDGE:  bus.DAT_O = zext(edge_mode);
         default: bus.DAT_O = '0;
      endcase
   end

   assign IRQ_O     = irq_q;
   assign ISR_IDX_O = isr_idx;

endmodule

// File: tb/tb_irq_ctrl.sv
// Bench for irq_ctrl: directed vector table, hand-written reset sequence and a
// randomized run against a cycle-level reference model.
module tb_irq_ctrl;
   localparam int N = 6;

   logic         CLK_I = 1'b0;
   logic         RST_I;
   logic [N-1:0] IRQ_SRC_I;
   logic         ACK_I;
   logic         IRQ_O;
   logic [4:0]   ISR_IDX_O;

   irq_ctrl_if bus();

   irq_ctrl #(.N_SRC(N)) dut (
      .CLK_I     (CLK_I),
      .RST_I     (RST_I),
      .bus       (bus),
      .IRQ_SRC_I (IRQ_SRC_I),
      .ACK_I     (ACK_I),
      .IRQ_O     (IRQ_O),
      .ISR_IDX_O (ISR_IDX_O)
   );

   always #5 CLK_I = ~CLK_I;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic        we;
      logic [1:0]  add;
      logic [31:0] dat;
      logic [5:0]  src;
      logic        ack;
      logic        eirq;
      logic [4:0]  eidx;
      logic [1:0]  rd;
      logic [31:0] erd;
   } vec_t;

   vec_t tbl[$];

   // Reference model: registers as plain vectors, state as 0=idle 1=request 2=service.
   logic [N-1:0] m_mask, m_pend, m_edge, m_prev;
   int           m_state;
   int           m_idx;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic model_reset();
      m_mask  = '0;
      m_pend  = '0;
      m_edge  = '0;
      m_prev  = '0;
      m_state = 0;
      m_idx   = 0;
   endtask

   task automatic model_step();
      int           win;
      logic [N-1:0] np;
      bit           rise, wclr, aclr;
      win = -1;
      for (int i = 0; i < N; i++)
         if (m_pend[i] && m_mask[i] && win < 0) win = i;
      for (int i = 0; i < N; i++) begin
         rise  = IRQ_SRC_I[i] && (!m_edge[i] || !m_prev[i]);
         wclr  = bus.WE_I && bus.ADD_I == 2'd1 && bus.DAT_I[i];
         aclr  = m_state == 1 && ACK_I && win == i && m_edge[i];
         np[i] = rise || (m_pend[i] && !wclr && !aclr);
      end
      if (m_state == 0) begin
         if (win >= 0) m_state = 1;
      end else if (m_state == 1) begin
         if (win < 0) m_state = 0;
         else if (ACK_I) begin
            m_state = 2;
            m_idx   = win;
         end
      end else begin
         if (bus.WE_I && bus.ADD_I == 2'd2) m_state = 0;
      end
      if (bus.WE_I && bus.ADD_I == 2'd0) m_mask = bus.DAT_I[N-1:0];
      if (bus.WE_I && bus.ADD_I == 2'd3) m_edge = bus.DAT_I[N-1:0];
      m_pend = np;
      m_prev = IRQ_SRC_I;
   endtask

   function automatic logic [31:0] m_read(input logic [1:0] a);
      case (a)
         2'd0:    return 32'(m_mask);
         2'd1:    return 32'(m_pend);
         2'd2:    return (32'(m_state) << 8) + (m_state == 2 ? 32'h80 : 32'h0) + 32'(m_idx);
         default: return 32'(m_edge);
      endcase
   endfunction

   task automatic cyc();
      model_step();
      @(posedge CLK_I);
      #1;
   endtask

   task automatic drive(input logic we, input logic [1:0] add, input logic [31:0] dat,
                        input logic [5:0] src, input logic ack);
      bus.WE_I  = we;
      bus.ADD_I = add;
      bus.DAT_I = dat;
      IRQ_SRC_I = src;
      ACK_I     = ack;
   endtask

   task automatic add_row(input logic we, input logic [1:0] add, input logic [31:0] dat,
                          input logic [5:0] src, input logic ack, input logic eirq,
                          input logic [4:0] eidx, input logic [1:0] rd, input logic [31:0] erd);
      vec_t v;
      v.we = we; v.add = add; v.dat = dat; v.src = src; v.ack = ack;
      v.eirq = eirq; v.eidx = eidx; v.rd = rd; v.erd = erd;
      tbl.push_back(v);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // we add dat src ack | irq idx rd expected-read
      add_row(0, 0, 32'h0,  6'h00, 0, 0, 0, 0, 32'h0);
      add_row(0, 0, 32'h0,  6'h02, 0, 0, 0, 1, 32'h2);   // masked level pulse latches
      add_row(0, 0, 32'h0,  6'h00, 0, 0, 0, 1, 32'h2);
      add_row(0, 0, 32'h0,  6'h00, 0, 0, 0, 2, 32'h0);
      add_row(1, 1, 32'h2,  6'h00, 0, 0, 0, 1, 32'h0);
      add_row(1, 0, 32'h3F, 6'h00, 0, 0, 0, 0, 32'h3F);
      add_row(1, 3, 32'hFF, 6'h00, 0, 0, 0, 3, 32'h3F);  // bits above N_SRC dropped
      add_row(0, 0, 32'h0,  6'h04, 0, 0, 0, 1, 32'h4);
      add_row(0, 0, 32'h0,  6'h00, 0, 1, 0, 2, 32'h100);
      add_row(0, 0, 32'h0,  6'h00, 1, 0, 2, 1, 32'h0);
      add_row(0, 0, 32'h0,  6'h00, 0, 0, 2, 2, 32'h282);
      add_row(1, 2, 32'h0,  6'h00, 0, 0, 2, 2, 32'h002);
      add_row(0, 0, 32'h0,  6'h00, 0, 0, 2, 2, 32'h002);
      add_row(0, 0, 32'h0,  6'h12, 0, 0, 2, 1, 32'h12);  // priority pair 4 and 1
      add_row(0, 0, 32'h0,  6'h12, 0, 1, 2, 1, 32'h12);
      add_row(0, 0, 32'h0,  6'h00, 1, 0, 1, 1, 32'h10);
      add_row(1, 2, 32'h0,  6'h00, 0, 0, 1, 2, 32'h001);
      add_row(0, 0, 32'h0,  6'h00, 0, 1, 1, 2, 32'h101);
      add_row(0, 0, 32'h0,  6'h00, 1, 0, 4, 2, 32'h284);
      add_row(1, 2, 32'h0,  6'h00, 0, 0, 4, 1, 32'h0);
      add_row(0, 0, 32'h0,  6'h20, 0, 0, 4, 1, 32'h20);  // withdrawal
      add_row(0, 0, 32'h0,  6'h00, 0, 1, 4, 2, 32'h104);
      add_row(1, 0, 32'h0,  6'h00, 0, 1, 4, 0, 32'h0);
      add_row(0, 0, 32'h0,  6'h00, 0, 0, 4, 2, 32'h004);
      add_row(0, 0, 32'h0,  6'h00, 1, 0, 4, 2, 32'h004);
      add_row(0, 0, 32'h0,  6'h00, 0, 0, 4, 1, 32'h20);
      add_row(1, 1, 32'h28, 6'h08, 0, 0, 4, 1, 32'h08);  // set wins over clear
      add_row(1, 1, 32'h08, 6'h00, 0, 0, 4, 1, 32'h0);
      add_row(1, 3, 32'h0,  6'h00, 0, 0, 4, 3, 32'h0);   // level timer
      add_row(1, 0, 32'h1,  6'h01, 0, 0, 4, 1, 32'h1);
      add_row(0, 0, 32'h0,  6'h01, 0, 1, 4, 1, 32'h1);
      add_row(0, 0, 32'h0,  6'h01, 1, 0, 0, 1, 32'h1);
      add_row(0, 0, 32'h0,  6'h01, 0, 0, 0, 2, 32'h280);
      add_row(1, 2, 32'h0,  6'h01, 0, 0, 0, 2, 32'h000);
      add_row(0, 0, 32'h0,  6'h01, 0, 1, 0, 2, 32'h100);
      add_row(0, 0, 32'h0,  6'h01, 1, 0, 0, 2, 32'h280);
      add_row(1, 1, 32'h1,  6'h00, 0, 0, 0, 1, 32'h0);
      add_row(1, 2, 32'h0,  6'h00, 0, 0, 0, 2, 32'h000);
      add_row(0, 0, 32'h0,  6'h00, 0, 0, 0, 1, 32'h0);

      RST_I = 1'b1;
      drive(0, 0, 32'h0, 6'h00, 0);
      model_reset();
      #12;
      chk("reset irq", 32'(IRQ_O), 32'h0);
      chk("reset idx", 32'(ISR_IDX_O), 32'h0);
      for (int a = 0; a < 4; a++) begin
         bus.ADD_I = 2'(a);
         #1;
         chk($sformatf("reset read%0d", a), bus.DAT_O, 32'h0);
      end
      @(negedge CLK_I);
      RST_I = 1'b0;

      for (int i = 0; i < tbl.size(); i++) begin
         drive(tbl[i].we, tbl[i].add, tbl[i].dat, tbl[i].src, tbl[i].ack);
         cyc();
         bus.WE_I = 1'b0;
         ACK_I    = 1'b0;
         chk($sformatf("row%0d irq", i), 32'(IRQ_O), 32'(tbl[i].eirq));
         chk($sformatf("row%0d idx", i), 32'(ISR_IDX_O), 32'(tbl[i].eidx));
         bus.ADD_I = tbl[i].rd;
         #1;
         chk($sformatf("row%0d read%0d", i, tbl[i].rd), bus.DAT_O, tbl[i].erd);
      end

      // Reach SERVICE on source 3, then reset asynchronously between clock edges.
      drive(1, 0, 32'h3F, 6'h00, 0); cyc();
      drive(1, 3, 32'h3F, 6'h08, 0); cyc();
      drive(0, 0, 32'h0,  6'h00, 0); cyc();
      chk("seq req irq", 32'(IRQ_O), 32'h1);
      drive(0, 0, 32'h0,  6'h00, 1); cyc();
      drive(0, 2, 32'h0,  6'h00, 0);
      chk("seq service idx", 32'(ISR_IDX_O), 32'h3);
      #1;
      chk("seq cause", bus.DAT_O, 32'h283);
      RST_I = 1'b1;
      #1;
      chk("async rst irq", 32'(IRQ_O), 32'h0);
      chk("async rst idx", 32'(ISR_IDX_O), 32'h0);
      for (int a = 0; a < 4; a++) begin
         bus.ADD_I = 2'(a);
         #1;
         chk($sformatf("async rst read%0d", a), bus.DAT_O, 32'h0);
      end
      model_reset();
      RST_I = 1'b0;

      for (int c = 0; c < 3000; c++) begin
         if ($urandom_range(0, 9) < 3) IRQ_SRC_I = N'($urandom_range(0, 63));
         ACK_I     = ($urandom_range(0, 3) == 0);
         bus.WE_I  = ($urandom_range(0, 3) == 0);
         bus.ADD_I = 2'($urandom_range(0, 3));
         bus.DAT_I = $urandom;
         cyc();
         bus.WE_I = 1'b0;
         ACK_I    = 1'b0;
         chk($sformatf("rand%0d irq", c), 32'(IRQ_O), (m_state == 1) ? 32'h1 : 32'h0);
         chk($sformatf("rand%0d idx", c), 32'(ISR_IDX_O), 32'(m_idx));
         bus.ADD_I = 2'($urandom_range(0, 3));
         #1;
         chk($sformatf("rand%0d read%0d", c, bus.ADD_I), bus.DAT_O, m_read(bus.ADD_I));
         if ($urandom_range(0, 299) == 0) begin
            RST_I = 1'b1;
            #1;
            model_reset();
            chk($sformatf("rand%0d rst idx", c), 32'(ISR_IDX_O), 32'h0);
            RST_I = 1'b0;
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
